// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32 memory-access pipeline stage (LW/SW with timeout, ALU pass-through)
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_we,
    output logic        misalign,
    output logic        timeout
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic           store_q, store_d;
    logic [4:0]     rd_q, rd_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    sdata_q, sdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    wb_data_q, wb_data_d;
    logic           wb_we_q, wb_we_d;
    logic           misalign_q, misalign_d;
    logic           timeout_q, timeout_d;

    logic is_mem_op;
    logic is_alu_op;

    assign is_mem_op = ((opcode == OP_LOAD) || (opcode == OP_STORE)) && (funct3 == 3'b010);
    assign is_alu_op = (opcode == OP_IMM) || (opcode == OP_REG) ||
                       (opcode == OP_LUI) || (opcode == OP_AUIPC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            store_q    <= 1'b0;
            rd_q       <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            cnt_q      <= '0;
            wb_data_q  <= '0;
            wb_we_q    <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            cnt_q      <= cnt_d;
            wb_data_q  <= wb_data_d;
            wb_we_q    <= wb_we_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        cnt_d      = cnt_q;
        wb_data_d  = wb_data_q;
        wb_we_d    = wb_we_q;
        misalign_d = misalign_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    store_d    = (opcode == OP_STORE);
                    rd_d       = rd;
                    addr_d     = alu_result;
                    sdata_d    = store_data;
                    wb_data_d  = '0;
                    wb_we_d    = 1'b0;
                    misalign_d = 1'b0;
                    timeout_d  = 1'b0;
                    state_d    = S_RESP;
                    if (is_mem_op) begin
                        if (alu_result[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = S_REQ;
                        end
                    end else if (is_alu_op) begin
                        wb_data_d = alu_result;
                        wb_we_d   = (rd != 5'd0);
                    end
                end
            end
            // Abort wins over a grant on the last budgeted cycle so REQ+WAIT never overruns.
            S_REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end else if (dmem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (dmem_rvalid) begin
                    if (!store_q) begin
                        wb_data_d = dmem_rdata;
                        wb_we_d   = (rd_q != 5'd0);
                    end
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready   = (state_q == S_IDLE);
    assign dmem_req   = (state_q == S_REQ);
    assign dmem_we    = dmem_req & store_q;
    assign dmem_addr  = dmem_req ? addr_q : 32'd0;
    assign dmem_wdata = dmem_we ? sdata_q : 32'd0;
    assign dmem_wstrb = dmem_we ? 4'b1111 : 4'b0000;
    assign out_valid  = (state_q == S_RESP);
    assign wb_rd      = rd_q;
    assign wb_data    = wb_data_q;
    assign wb_we      = out_valid & wb_we_q;
    assign misalign   = out_valid & misalign_q;
    assign timeout    = out_valid & timeout_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - table-driven and randomized bench for mem_access_stage
module tb_mem_access_stage;

    localparam int T = 4;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] REG = 7'b0110011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;
    localparam logic [6:0] BR  = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result, store_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        out_valid, out_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we, misalign, timeout;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .rd(rd), .alu_result(alu_result),
        .store_data(store_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_we(wb_we), .misalign(misalign), .timeout(timeout)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu, sd, rdata;
        int          r, w, stall;
        bit          rvg;
        int          e_lat, e_req;
        bit          e_we, e_mis, e_to, e_chkd;
        logic [31:0] e_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r_d,
                                input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] rdata,
                                input int r, input int w, input int stall, input bit rvg,
                                input int lat, input int req, input bit we, input bit mis,
                                input bit to, input bit chkd, input logic [31:0] data);
        vec_t v;
        v.op = op; v.f3 = f3; v.rd = r_d; v.alu = alu; v.sd = sd; v.rdata = rdata;
        v.r = r; v.w = w; v.stall = stall; v.rvg = rvg;
        v.e_lat = lat; v.e_req = req; v.e_we = we; v.e_mis = mis; v.e_to = to;
        v.e_chkd = chkd; v.e_data = data;
        return v;
    endfunction

    // Reference: classify the instruction, then derive timing from REQ/WAIT cycle budget.
    function automatic vec_t model(input vec_t v);
        vec_t o = v;
        bit mem = ((v.op == LW) || (v.op == SW)) && (v.f3 == 3'b010);
        bit aluop = (v.op == IMM) || (v.op == REG) || (v.op == LUI) || (v.op == AUI);
        o.e_lat = 1; o.e_req = 0; o.e_we = 0; o.e_mis = 0; o.e_to = 0; o.e_chkd = 0; o.e_data = 0;
        if (mem && (v.alu % 4 != 0)) begin
            o.e_mis = 1;
        end else if (mem) begin
            if (v.r >= T || v.r + v.w > T) begin
                o.e_to = 1;
                o.e_lat = 1 + T;
                o.e_req = (v.r >= T) ? T : v.r;
            end else begin
                o.e_lat = 1 + v.r + v.w;
                o.e_req = v.r;
                o.e_chkd = 1;
                if (v.op == LW) begin
                    o.e_data = v.rdata;
                    o.e_we = (v.rd != 0);
                end
            end
        end else if (aluop) begin
            o.e_data = v.alu;
            o.e_we = (v.rd != 0);
            o.e_chkd = 1;
        end
        return o;
    endfunction

    task automatic chk_rec(input string tag, input vec_t v);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, v.rd});
        chk({tag, ".wb_we"}, {31'd0, wb_we}, {31'd0, v.e_we});
        chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, v.e_mis});
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, v.e_to});
        if (v.e_chkd) chk({tag, ".wb_data"}, wb_data, v.e_data);
    endtask

    task automatic run(input string tag, input vec_t v);
        int reqc = 0, waitc = 0, lat = 0;
        bit granted = 0, seen = 0;
        bit is_st = (v.op == SW);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1; opcode = v.op; funct3 = v.f3; rd = v.rd;
        alu_result = v.alu; store_data = v.sd;
        out_ready = 0; dmem_gnt = 0; dmem_rvalid = 0;
        step();
        for (int c = 1; c <= 40 && !seen; c++) begin
            in_valid = 1; opcode = 7'($urandom); funct3 = 3'($urandom); rd = 5'($urandom);
            alu_result = $urandom; store_data = $urandom;
            dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
            if (out_valid) begin
                seen = 1; lat = c;
            end else if (dmem_req) begin
                reqc++;
                chk({tag, ".addr"}, dmem_addr, v.alu);
                chk({tag, ".we"}, {31'd0, dmem_we}, {31'd0, is_st});
                chk({tag, ".wstrb"}, {28'd0, dmem_wstrb}, is_st ? 32'hF : 32'h0);
                chk({tag, ".wdata"}, dmem_wdata, is_st ? v.sd : 32'h0);
                if (reqc == v.r) begin
                    dmem_gnt = 1; granted = 1; dmem_rvalid = v.rvg;
                end else begin
                    dmem_rvalid = 1'($urandom_range(0, 1));
                end
            end else if (granted) begin
                waitc++;
                if (waitc == v.w) begin
                    dmem_rvalid = 1; dmem_rdata = v.rdata;
                end
            end
            if (!seen) step();
        end
        dmem_gnt = 0; dmem_rvalid = 0;
        chk({tag, ".latency"}, lat, v.e_lat);
        chk({tag, ".req_cycles"}, reqc, v.e_req);
        chk_rec(tag, v);
        for (int s = 0; s < v.stall; s++) begin
            dmem_rvalid = 1'($urandom_range(0, 1));
            step();
            chk_rec({tag, ".held"}, v);
        end
        out_ready = 1; in_valid = 0; dmem_rvalid = 0;
        step();
        out_ready = 0;
        chk({tag, ".ret_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".ret_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    vec_t tbl[12];
    vec_t rv;
    logic [6:0] ops[8];

    initial begin
        rst_n = 0; in_valid = 0; opcode = 0; funct3 = 0; rd = 0; alu_result = 0;
        store_data = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0; out_ready = 0;
        step(); step();
        chk("rst.ctl", {17'd0, dmem_req, dmem_we, out_valid, wb_we, misalign, timeout, dmem_wstrb, wb_rd}, 32'd0);
        chk("rst.addr", dmem_addr, 32'd0);
        chk("rst.wdata", dmem_wdata, 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        rst_n = 1;
        step();
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

        //            op   f3  rd  alu           sd            rdata         r   w  st rvg lat req we mis to chkd data
        tbl[0]  = mk(IMM, 0, 5,  32'h0000002A, 0,            0,            0,  0, 0, 0, 1, 0, 1, 0, 0, 1, 32'h2A);
        tbl[1]  = mk(LW,  2, 3,  32'h00000100, 0,            32'hDEADBEEF, 3,  1, 0, 0, 5, 3, 1, 0, 0, 1, 32'hDEADBEEF);
        tbl[2]  = mk(SW,  2, 4,  32'h00000204, 32'h12345678, 0,            1,  1, 3, 0, 3, 1, 0, 0, 0, 1, 32'h0);
        tbl[3]  = mk(LW,  2, 6,  32'h00000102, 0,            0,            1,  1, 0, 0, 1, 0, 0, 1, 0, 0, 32'h0);
        tbl[4]  = mk(LW,  2, 7,  32'h00000040, 0,            0,            99, 1, 0, 0, 5, 4, 0, 0, 1, 0, 32'h0);
        tbl[5]  = mk(LW,  2, 0,  32'h00000080, 0,            32'h55AA33CC, 1,  1, 1, 1, 3, 1, 0, 0, 0, 1, 32'h55AA33CC);
        tbl[6]  = mk(LUI, 0, 31, 32'hABCDE000, 0,            0,            0,  0, 0, 0, 1, 0, 1, 0, 0, 1, 32'hABCDE000);
        tbl[7]  = mk(REG, 0, 0,  32'h00000099, 0,            0,            0,  0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h99);
        tbl[8]  = mk(LW,  0, 8,  32'h00000101, 0,            0,            1,  1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        tbl[9]  = mk(BR,  2, 9,  32'h00000010, 0,            0,            0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        tbl[10] = mk(AUI, 0, 1,  32'h80001000, 0,            0,            0,  0, 2, 0, 1, 0, 1, 0, 0, 1, 32'h80001000);
        tbl[11] = mk(SW,  2, 2,  32'h00000300, 32'hCAFEF00D, 0,            2,  3, 0, 0, 5, 2, 0, 0, 1, 0, 32'h0);
        foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i]);

        ops = '{LW, SW, IMM, REG, LUI, AUI, BR, 7'b1101111};
        for (int n = 0; n < 150; n++) begin
            rv.op = ops[$urandom_range(0, 7)];
            rv.f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b010;
            rv.rd = 5'($urandom);
            rv.alu = $urandom;
            if ($urandom_range(0, 3) != 0) rv.alu[1:0] = 2'b00;
            rv.sd = $urandom; rv.rdata = $urandom;
            rv.r = $urandom_range(1, 5); rv.w = $urandom_range(1, 3);
            rv.stall = $urandom_range(0, 2); rv.rvg = 1'($urandom_range(0, 1));
            run($sformatf("rnd%0d", n), model(rv));
        end

        // Reset while a load is outstanding: the later response must be ignored.
        in_valid = 1; opcode = LW; funct3 = 3'b010; rd = 5'd9; alu_result = 32'h300;
        step();
        in_valid = 0; dmem_gnt = 1;
        step();
        dmem_gnt = 0;
        chk("wrst.in_wait", {30'd0, dmem_req, out_valid}, 32'd0);
        #2 rst_n = 0;
        #1;
        chk("wrst.ctl", {17'd0, dmem_req, dmem_we, out_valid, wb_we, misalign, timeout, dmem_wstrb, wb_rd}, 32'd0);
        chk("wrst.addr", dmem_addr, 32'd0);
        chk("wrst.wb_data", wb_data, 32'd0);
        step();
        rst_n = 1; dmem_rvalid = 1; dmem_rdata = 32'hBAD0BAD0;
        step();
        dmem_rvalid = 0;
        for (int k = 0; k < 3; k++) begin
            chk("wrst.stale_out_valid", {31'd0, out_valid}, 32'd0);
            step();
        end
        chk("wrst.in_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
